// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the shared memory port and the arbiter.
// The arbiter connects through the slave modport; the requesters and memory model use master.
interface mem_port_arbiter_if #(
    parameter int XLEN = 32
);
    logic                if_req;
    logic [XLEN-1:0]     if_addr;
    logic                if_done;
    logic [XLEN-1:0]     if_rdata;
    logic                ls_req;
    logic                ls_we;
    logic [XLEN-1:0]     ls_addr;
    logic [XLEN-1:0]     ls_wdata;
    logic [XLEN/8-1:0]   ls_wstrb;
    logic                ls_done;
    logic [XLEN-1:0]     ls_rdata;
    logic [XLEN-1:0]     port_addr;
    logic                port_we;
    logic [XLEN-1:0]     port_wdata;
    logic [XLEN/8-1:0]   port_wstrb;
    logic [XLEN-1:0]     port_rdata;
    logic                busy;

    modport slave (
        input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb, port_rdata,
        output if_done, if_rdata, ls_done, ls_rdata,
               port_addr, port_we, port_wdata, port_wstrb, busy
    );

    modport master (
        output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb, port_rdata,
        input  if_done, if_rdata, ls_done, ls_rdata,
               port_addr, port_we, port_wdata, port_wstrb, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between instruction fetch and load/store.
// Loads win over fetches; stores finish in the grant cycle, reads hold the latched address until done.
module mem_port_arbiter #(
    parameter int XLEN         = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic               clock,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RD_IF = 2'd1,
        RD_LS = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(READ_LATENCY - 1);

    state_t            state_reg;
    logic [3:0]        cnt_reg;
    logic [XLEN-1:0]   addr_reg;
    logic [XLEN-1:0]   if_rdata_reg;
    logic [XLEN-1:0]   ls_rdata_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            addr_reg     <= '0;
            if_rdata_reg <= '0;
            ls_rdata_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    // A store completes in place, so only loads and fetches leave IDLE.
                    if (bus.ls_req && !bus.ls_we) begin
                        state_reg <= RD_LS;
                        cnt_reg   <= CNT_INIT;
                        addr_reg  <= bus.ls_addr;
                    end else if (!bus.ls_req && bus.if_req) begin
                        state_reg <= RD_IF;
                        cnt_reg   <= CNT_INIT;
                        addr_reg  <= bus.if_addr;
                    end
                end
                RD_IF: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        if_rdata_reg <= bus.port_rdata;
                        state_reg    <= IDLE;
                    end
                end
                RD_LS: begin
                    if (cnt_reg != 4'd0) begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end else begin
                        ls_rdata_reg <= bus.port_rdata;
                        state_reg    <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.port_addr  = '0;
        bus.port_we    = 1'b0;
        bus.port_wdata = '0;
        bus.port_wstrb = '0;
        bus.busy       = 1'b0;
        bus.if_done    = 1'b0;
        bus.ls_done    = 1'b0;
        bus.if_rdata   = if_rdata_reg;
        bus.ls_rdata   = ls_rdata_reg;
        case (state_reg)
            IDLE: begin
                if (bus.ls_req) begin
                    bus.port_addr = bus.ls_addr;
                    if (bus.ls_we) begin
                        bus.port_we    = 1'b1;
                        bus.port_wdata = bus.ls_wdata;
                        bus.port_wstrb = bus.ls_wstrb;
                        bus.ls_done    = 1'b1;
                    end
                end else if (bus.if_req) begin
                    bus.port_addr = bus.if_addr;
                end
            end
            RD_IF: begin
                bus.port_addr = addr_reg;
                bus.busy      = 1'b1;
                if (cnt_reg == 4'd0) begin
                    bus.if_done  = 1'b1;
                    bus.if_rdata = bus.port_rdata;
                end
            end
            RD_LS: begin
                bus.port_addr = addr_reg;
                bus.busy      = 1'b1;
                if (cnt_reg == 4'd0) begin
                    bus.ls_done  = 1'b1;
                    bus.ls_rdata = bus.port_rdata;
                end
            end
            default: begin
                bus.port_addr = '0;
            end
        endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at READ_LATENCY=1, one at READ_LATENCY=3.
module tb_mem_port_arbiter;
    logic clock;
    logic reset;
    int   checks;
    int   passes;

    mem_port_arbiter_if #(.XLEN(32)) b1 ();
    mem_port_arbiter_if #(.XLEN(32)) b3 ();

    mem_port_arbiter #(.XLEN(32), .READ_LATENCY(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (b1)
    );

    mem_port_arbiter #(.XLEN(32), .READ_LATENCY(3)) dut3 (
        .clock (clock),
        .reset (reset),
        .bus   (b3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Inputs change 1 time unit after the edge; outputs are sampled 4 units after it.
    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic idle_inputs();
        b1.if_req = 0; b1.if_addr = 0; b1.ls_req = 0; b1.ls_we = 0;
        b1.ls_addr = 0; b1.ls_wdata = 0; b1.ls_wstrb = 0; b1.port_rdata = 0;
        b3.if_req = 0; b3.if_addr = 0; b3.ls_req = 0; b3.ls_we = 0;
        b3.ls_addr = 0; b3.ls_wdata = 0; b3.ls_wstrb = 0; b3.port_rdata = 0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        next_cycle();
        next_cycle();
        settle();
        checks++;
        if ({b1.if_done, b1.ls_done, b1.busy, b1.port_we} !== 4'b0000)
            $display("FAIL reset_ctl1: got %b expected 0000", {b1.if_done, b1.ls_done, b1.busy, b1.port_we});
        else passes++;
        checks++;
        if ({b3.if_done, b3.ls_done, b3.busy, b3.port_we} !== 4'b0000)
            $display("FAIL reset_ctl3: got %b expected 0000", {b3.if_done, b3.ls_done, b3.busy, b3.port_we});
        else passes++;
        checks++;
        if ({b1.if_rdata, b1.ls_rdata, b1.port_addr} !== 96'h0)
            $display("FAIL reset_data1: got %h expected 0", {b1.if_rdata, b1.ls_rdata, b1.port_addr});
        else passes++;
        next_cycle();
        reset = 1'b0;
        $display("[%0t] reset released", $time);
    endtask

    task automatic test_fetch();
        next_cycle();
        b1.if_req = 1; b1.if_addr = 32'h100; b1.port_rdata = 32'hDEADBEEF;
        settle();
        checks++;
        if (b1.port_addr !== 32'h100 || b1.if_done !== 1'b0 || b1.busy !== 1'b0)
            $display("FAIL fetch_grant: addr=%h done=%b busy=%b expected 100/0/0", b1.port_addr, b1.if_done, b1.busy);
        else passes++;
        next_cycle();
        settle();
        checks++;
        if (b1.port_addr !== 32'h100 || b1.if_done !== 1'b1 || b1.busy !== 1'b1)
            $display("FAIL fetch_done: addr=%h done=%b busy=%b expected 100/1/1", b1.port_addr, b1.if_done, b1.busy);
        else passes++;
        checks++;
        if (b1.if_rdata !== 32'hDEADBEEF)
            $display("FAIL fetch_rdata: got %h expected deadbeef", b1.if_rdata);
        else passes++;
        next_cycle();
        b1.if_req = 0; b1.port_rdata = 32'h0;
        settle();
        checks++;
        if (b1.if_rdata !== 32'hDEADBEEF || b1.if_done !== 1'b0 || b1.port_addr !== 32'h0)
            $display("FAIL fetch_hold: rdata=%h done=%b addr=%h expected deadbeef/0/0", b1.if_rdata, b1.if_done, b1.port_addr);
        else passes++;
        $display("[%0t] fetch 0x100 -> %h", $time, b1.if_rdata);
    endtask

    task automatic test_priority();
        next_cycle();
        b1.if_req = 1; b1.if_addr = 32'h100;
        b1.ls_req = 1; b1.ls_we = 0; b1.ls_addr = 32'h200; b1.port_rdata = 32'hCAFE0001;
        settle();
        checks++;
        if (b1.port_addr !== 32'h200 || b1.ls_done !== 1'b0)
            $display("FAIL prio_grant: addr=%h ls_done=%b expected 200/0", b1.port_addr, b1.ls_done);
        else passes++;
        next_cycle();
        settle();
        checks++;
        if (b1.ls_done !== 1'b1 || b1.if_done !== 1'b0 || b1.ls_rdata !== 32'hCAFE0001 || b1.port_addr !== 32'h200)
            $display("FAIL prio_ls_done: ls_done=%b if_done=%b rdata=%h addr=%h expected 1/0/cafe0001/200",
                     b1.ls_done, b1.if_done, b1.ls_rdata, b1.port_addr);
        else passes++;
        next_cycle();
        b1.ls_req = 0; b1.port_rdata = 32'hF00D0002;
        settle();
        checks++;
        if (b1.port_addr !== 32'h100 || b1.if_done !== 1'b0 || b1.busy !== 1'b0)
            $display("FAIL prio_if_grant: addr=%h done=%b busy=%b expected 100/0/0", b1.port_addr, b1.if_done, b1.busy);
        else passes++;
        next_cycle();
        settle();
        checks++;
        if (b1.if_done !== 1'b1 || b1.if_rdata !== 32'hF00D0002 || b1.ls_done !== 1'b0 || b1.ls_rdata !== 32'hCAFE0001)
            $display("FAIL prio_if_done: if_done=%b if_rdata=%h ls_done=%b ls_rdata=%h expected 1/f00d0002/0/cafe0001",
                     b1.if_done, b1.if_rdata, b1.ls_done, b1.ls_rdata);
        else passes++;
        next_cycle();
        b1.if_req = 0;
        $display("[%0t] load 0x200 -> %h then fetch 0x100 -> %h", $time, b1.ls_rdata, b1.if_rdata);
    endtask

    task automatic test_store();
        next_cycle();
        b1.ls_req = 1; b1.ls_we = 1; b1.ls_addr = 32'h40; b1.ls_wdata = 32'h12345678; b1.ls_wstrb = 4'hF;
        settle();
        checks++;
        if (b1.port_we !== 1'b1 || b1.ls_done !== 1'b1 || b1.busy !== 1'b0)
            $display("FAIL store_ctl: we=%b done=%b busy=%b expected 1/1/0", b1.port_we, b1.ls_done, b1.busy);
        else passes++;
        checks++;
        if (b1.port_addr !== 32'h40 || b1.port_wdata !== 32'h12345678 || b1.port_wstrb !== 4'hF)
            $display("FAIL store_bus: addr=%h wdata=%h wstrb=%h expected 40/12345678/f", b1.port_addr, b1.port_wdata, b1.port_wstrb);
        else passes++;
        next_cycle();
        b1.ls_req = 0; b1.ls_we = 0;
        settle();
        checks++;
        if (b1.port_we !== 1'b0 || b1.ls_done !== 1'b0 || b1.port_wdata !== 32'h0 || b1.port_wstrb !== 4'h0)
            $display("FAIL store_idle: we=%b done=%b wdata=%h wstrb=%h expected 0/0/0/0", b1.port_we, b1.ls_done, b1.port_wdata, b1.port_wstrb);
        else passes++;
        $display("[%0t] store 0x40 <= 12345678", $time);
    endtask

    task automatic test_latency3();
        next_cycle();
        b3.ls_req = 1; b3.ls_we = 0; b3.ls_addr = 32'h80; b3.port_rdata = 32'h0BADF00D;
        settle();
        checks++;
        if (b3.port_addr !== 32'h80 || b3.busy !== 1'b0)
            $display("FAIL lat3_grant: addr=%h busy=%b expected 80/0", b3.port_addr, b3.busy);
        else passes++;
        for (int c = 1; c <= 2; c++) begin
            next_cycle();
            b3.ls_addr = 32'h999;
            b3.ls_we   = 1'b1;
            settle();
            checks++;
            if (b3.busy !== 1'b1 || b3.ls_done !== 1'b0 || b3.port_addr !== 32'h80 || b3.port_we !== 1'b0)
                $display("FAIL lat3_wait%0d: busy=%b done=%b addr=%h we=%b expected 1/0/80/0",
                         c, b3.busy, b3.ls_done, b3.port_addr, b3.port_we);
            else passes++;
        end
        next_cycle();
        settle();
        checks++;
        if (b3.busy !== 1'b1 || b3.ls_done !== 1'b1 || b3.port_addr !== 32'h80 || b3.ls_rdata !== 32'h0BADF00D)
            $display("FAIL lat3_done: busy=%b done=%b addr=%h rdata=%h expected 1/1/80/0badf00d",
                     b3.busy, b3.ls_done, b3.port_addr, b3.ls_rdata);
        else passes++;
        next_cycle();
        b3.ls_req = 0; b3.ls_we = 0;
        settle();
        checks++;
        if (b3.busy !== 1'b0 || b3.ls_done !== 1'b0)
            $display("FAIL lat3_idle: busy=%b done=%b expected 0/0", b3.busy, b3.ls_done);
        else passes++;
        $display("[%0t] load 0x80 (latency 3) -> %h", $time, b3.ls_rdata);
    endtask

    task automatic test_reset_mid();
        int if_done_seen;
        if_done_seen = 0;
        next_cycle();
        b3.if_req = 1; b3.if_addr = 32'h100; b3.port_rdata = 32'h11111111;
        settle();
        next_cycle();
        reset = 1'b1;
        settle();
        checks++;
        if (b3.busy !== 1'b1)
            $display("FAIL rstmid_busy: got %b expected 1", b3.busy);
        else passes++;
        next_cycle();
        reset = 1'b0;
        b3.if_req = 0;
        b3.ls_req = 1; b3.ls_we = 0; b3.ls_addr = 32'h300; b3.port_rdata = 32'h33333333;
        settle();
        checks++;
        if (b3.busy !== 1'b0 || b3.if_done !== 1'b0 || b3.port_addr !== 32'h300 || b3.if_rdata !== 32'h0)
            $display("FAIL rstmid_idle: busy=%b if_done=%b addr=%h if_rdata=%h expected 0/0/300/0",
                     b3.busy, b3.if_done, b3.port_addr, b3.if_rdata);
        else passes++;
        for (int c = 1; c <= 3; c++) begin
            next_cycle();
            settle();
            if (b3.if_done === 1'b1) if_done_seen++;
        end
        checks++;
        if (b3.ls_done !== 1'b1 || b3.ls_rdata !== 32'h33333333 || b3.port_addr !== 32'h300)
            $display("FAIL rstmid_load: done=%b rdata=%h addr=%h expected 1/33333333/300", b3.ls_done, b3.ls_rdata, b3.port_addr);
        else passes++;
        checks++;
        if (if_done_seen !== 0)
            $display("FAIL rstmid_nodone: if_done pulses=%0d expected 0", if_done_seen);
        else passes++;
        next_cycle();
        b3.ls_req = 0;
        $display("[%0t] fetch aborted by reset, load 0x300 -> %h", $time, b3.ls_rdata);
    endtask

    task automatic test_back_to_back();
        next_cycle();
        b1.if_req = 1; b1.if_addr = 32'h100;
        b1.ls_req = 1; b1.ls_we = 1; b1.ls_addr = 32'h40; b1.ls_wdata = 32'h1; b1.ls_wstrb = 4'h3;
        settle();
        checks++;
        if (b1.ls_done !== 1'b1 || b1.port_we !== 1'b1 || b1.if_done !== 1'b0 || b1.port_addr !== 32'h40)
            $display("FAIL b2b_st1: done=%b we=%b if_done=%b addr=%h expected 1/1/0/40",
                     b1.ls_done, b1.port_we, b1.if_done, b1.port_addr);
        else passes++;
        next_cycle();
        b1.ls_addr = 32'h44; b1.ls_wdata = 32'h2; b1.ls_wstrb = 4'hC;
        settle();
        checks++;
        if (b1.ls_done !== 1'b1 || b1.port_addr !== 32'h44 || b1.port_wdata !== 32'h2 || b1.port_wstrb !== 4'hC)
            $display("FAIL b2b_st2: done=%b addr=%h wdata=%h wstrb=%h expected 1/44/2/c",
                     b1.ls_done, b1.port_addr, b1.port_wdata, b1.port_wstrb);
        else passes++;
        next_cycle();
        b1.ls_we = 0; b1.ls_addr = 32'h48; b1.port_rdata = 32'h0000ABCD;
        settle();
        checks++;
        if (b1.ls_done !== 1'b0 || b1.port_we !== 1'b0 || b1.port_addr !== 32'h48)
            $display("FAIL b2b_ld_grant: done=%b we=%b addr=%h expected 0/0/48", b1.ls_done, b1.port_we, b1.port_addr);
        else passes++;
        next_cycle();
        settle();
        checks++;
        if (b1.ls_done !== 1'b1 || b1.ls_rdata !== 32'h0000ABCD || b1.if_done !== 1'b0)
            $display("FAIL b2b_ld_done: done=%b rdata=%h if_done=%b expected 1/0000abcd/0", b1.ls_done, b1.ls_rdata, b1.if_done);
        else passes++;
        next_cycle();
        b1.ls_req = 0; b1.port_rdata = 32'h0000F00F;
        settle();
        checks++;
        if (b1.port_addr !== 32'h100 || b1.ls_done !== 1'b0 || b1.if_done !== 1'b0)
            $display("FAIL b2b_if_grant: addr=%h ls_done=%b if_done=%b expected 100/0/0", b1.port_addr, b1.ls_done, b1.if_done);
        else passes++;
        next_cycle();
        settle();
        checks++;
        if (b1.if_done !== 1'b1 || b1.if_rdata !== 32'h0000F00F)
            $display("FAIL b2b_if_done: done=%b rdata=%h expected 1/0000f00f", b1.if_done, b1.if_rdata);
        else passes++;
        next_cycle();
        b1.if_req = 0;
        $display("[%0t] stores 0x40,0x44, load 0x48 -> %h, fetch 0x100 -> %h", $time, b1.ls_rdata, b1.if_rdata);
    endtask

    initial begin
        checks = 0;
        passes = 0;
        reset  = 1'b1;
        idle_inputs();
        test_reset();
        test_fetch();
        test_priority();
        test_store();
        test_latency3();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the instruction-fetch stage and the memory (load/store) stage of the pipelined RV32I core.
- Sequences the fixed-latency read protocol: address is held stable until data is valid, then a one-cycle done pulse is returned to the winning requester.
- Stores complete in one cycle.
- The load and fetch stages drive this block instead of driving the memory port directly.

Parameters:
- XLEN, 32, data/address width.
- READ_LATENCY, 1, cycles from the address being presented to port_rdata being valid; legal range 1..15.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch read request; held until if_done.
- if_addr  in  XLEN  fetch address.
- if_done  out  1  one-cycle pulse: if_rdata valid this cycle.
- if_rdata  out  XLEN  fetch read data.
- ls_req  in  1  load/store request; held until ls_done.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  XLEN  load/store effective address.
- ls_wdata  in  XLEN  store data.
- ls_wstrb  in  XLEN/8  store byte enables.
- ls_done  out  1  one-cycle completion pulse.
- ls_rdata  out  XLEN  load data, valid when ls_done.
- port_addr  out  XLEN  memory address.
- port_we  out  1  memory write enable.
- port_wdata  out  XLEN  memory write data.
- port_wstrb  out  XLEN/8  memory byte enables.
- port_rdata  in  XLEN  memory read data.
- busy  out  1  read transaction in flight.

Behaviour:
- FSM states: IDLE, RD_IF, RD_LS. There is a 4-bit countdown cnt.
- Arbitration in IDLE uses fixed priority: ls_req wins over if_req, because the older instruction must drain.
- IDLE, ls_req=1 and ls_we=1:
  - Drive port_addr=ls_addr, port_we=1, port_wdata=ls_wdata, port_wstrb=ls_wstrb.
  - Assert ls_done the same cycle.
  - Stay in IDLE. Fetch waits that cycle.
- IDLE, ls_req=1 and ls_we=0:
  - Drive port_addr=ls_addr.
  - Load cnt=READ_LATENCY-1 and go to RD_LS.
- IDLE, only if_req=1:
  - Drive port_addr=if_addr.
  - Load cnt=READ_LATENCY-1 and go to RD_IF.
- IDLE, no request: port_addr=0, port_we=0, port_wdata=0, port_wstrb=0.
- RD_x states:
  - port_addr is driven from the address latched at grant; requester address changes are ignored.
  - port_we=0 and busy=1.
  - If cnt≠0, decrement cnt.
  - If cnt==0, assert x_done and pass port_rdata combinationally to x_rdata, then return to IDLE.
- Latency: a read granted in cycle t completes in cycle t+READ_LATENCY. The next grant is possible in cycle t+READ_LATENCY+1.
- Back-to-back stores from ls complete one per cycle. if_req is not served until ls_req drops.
- if_rdata and ls_rdata also hold their last completed value in a register. They equal port_rdata only in the done cycle, and the registered value otherwise.
- A requester deasserting req mid-read does not abort the read. The read completes and the done pulse still fires, and the requester ignores it.
- No request is granted while a read is in flight. Requests arriving then wait for IDLE.
- ls_we is sampled only at grant.
- Reset, including mid-transaction, takes effect at the next clock edge:
  - state=IDLE, cnt=0, and no done pulse is emitted.
  - if_done=0, ls_done=0, busy=0, port_we=0.
  - if_rdata=0 and ls_rdata=0 (registered copies cleared).
  - port_addr follows the IDLE rules after reset.
- Never more than one done pulse per cycle.

Test Plan:
- READ_LATENCY=1, if_req with if_addr=0x100, port_rdata=0xDEADBEEF -> port_addr=0x100 in cycles t and t+1; if_done=1 at t+1 with if_rdata=0xDEADBEEF.
- if_req and ls_req (load, 0x200) both raised at t -> ls_done at t+1; fetch granted at t+2 and if_done at t+3; port_addr = 0x200 then 0x100.
- Store ls_we=1, addr 0x40, wdata 0x12345678, wstrb 0xF -> port_we=1 and ls_done=1 in the same cycle, with no busy.
- READ_LATENCY=3 load at 0x80 -> busy for 3 cycles, ls_done at t+3, port_addr stable at 0x80 throughout.
- Reset asserted at t+1 of a READ_LATENCY=3 fetch -> no if_done; state IDLE; fresh ls load granted immediately after reset deasserts.
- Two consecutive stores then a load -> ls_done at t, t+1, t+3; fetch starved until ls_req drops.
